// File: rtl/bus_sentinel_ctrl.sv
// bus_sentinel_ctrl: masked-signature bus monitor with a sticky alarm and a serial hit dump.
// Define HIT_COUNTER_EN to add the saturating hit_cnt output.
module bus_sentinel_ctrl #(
    parameter int NSIG = 4,
    parameter int DW   = 64,
    parameter int IW   = 2
) (
    input  logic          clk,
    input  logic          rst_all,
    input  logic [DW-1:0] data,
    input  logic          data_vld,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [DW-1:0] cfg_sig,
    input  logic [DW-1:0] cfg_mask,
    input  logic          cfg_en,
    input  logic          arm,
    input  logic          disarm,
    output logic          alarm,
    output logic [IW-1:0] hit_idx,
    output logic          log_out,
    output logic          log_vld,
    input  logic          log_rdy,
    output logic          busy
`ifdef HIT_COUNTER_EN
    ,
    output logic [15:0]   hit_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DUMP  = 2'd2;

    localparam int SW = DW + IW;
    localparam int BW = $clog2(SW);
    localparam logic [BW-1:0] LAST_BEAT = BW'(SW - 1);

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   sig_q  [NSIG];
    logic [DW-1:0]   sig_d  [NSIG];
    logic [DW-1:0]   mask_q [NSIG];
    logic [DW-1:0]   mask_d [NSIG];
    logic [NSIG-1:0] en_q, en_d;
    logic            alarm_q, alarm_d;
    logic [IW-1:0]   hit_idx_q, hit_idx_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            log_vld_q, log_vld_d;
    logic            busy_q, busy_d;

    logic [NSIG-1:0] match;
    logic            hit_found;
    logic [IW-1:0]   hit_sel;

    // Descending scan so the lowest matching slot is the one left in hit_sel.
    always_comb begin
        match     = '0;
        hit_found = 1'b0;
        hit_sel   = '0;
        for (int i = 0; i < NSIG; i++) begin
            match[i] = en_q[i] & data_vld & ~|((data ^ sig_q[i]) & mask_q[i]);
        end
        for (int i = NSIG - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_found = 1'b1;
                hit_sel   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        mask_d    = mask_q;
        en_d      = en_q;
        alarm_d   = alarm_q;
        hit_idx_d = hit_idx_q;
        shift_d   = shift_q;
        beat_d    = beat_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    sig_d[cfg_idx]  = cfg_sig;
                    mask_d[cfg_idx] = cfg_mask;
                    en_d[cfg_idx]   = cfg_en;
                end
                if (arm && !disarm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    state_d   = S_IDLE;
                    alarm_d   = 1'b0;
                    hit_idx_d = '0;
                end else if (hit_found) begin
                    state_d   = S_DUMP;
                    alarm_d   = 1'b1;
                    hit_idx_d = hit_sel;
                    shift_d   = {hit_sel, data};
                    beat_d    = '0;
                end
            end
            S_DUMP: begin
                if (disarm) begin
                    state_d   = S_IDLE;
                    alarm_d   = 1'b0;
                    hit_idx_d = '0;
                    shift_d   = '0;
                    beat_d    = '0;
                end else if (log_rdy) begin
                    shift_d = shift_q >> 1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_ARMED;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d != S_IDLE);
        log_vld_d = (state_d == S_DUMP);
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q   <= S_IDLE;
            en_q      <= '0;
            alarm_q   <= 1'b0;
            hit_idx_q <= '0;
            shift_q   <= '0;
            beat_q    <= '0;
            log_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NSIG; i++) begin
                sig_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            alarm_q   <= alarm_d;
            hit_idx_q <= hit_idx_d;
            shift_q   <= shift_d;
            beat_q    <= beat_d;
            log_vld_q <= log_vld_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NSIG; i++) begin
                sig_q[i]  <= sig_d[i];
                mask_q[i] <= mask_d[i];
            end
        end
    end

    assign alarm   = alarm_q;
    assign hit_idx = hit_idx_q;
    assign log_out = shift_q[0];
    assign log_vld = log_vld_q;
    assign busy    = busy_q;

`ifdef HIT_COUNTER_EN
    // Counts every matching cycle while not idle, dump included; only rst_all clears it.
    logic [15:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (state_q != S_IDLE && |match && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`endif

endmodule
